// File: rtl/rgb2bayer.sv
// Re-mosaics a packed {B,G,R} pixel stream into an 8-bit Bayer raw stream.
// Pixel phase follows the demosaic stage: ph = {v[0],h[0]} ^ BAYER.
module rgb2bayer #(
  parameter logic [10:0] RAW_HPIXEL = 11'd1936,
  parameter logic [10:0] RAW_VPIXEL = 11'd1088,
  parameter int          BAYER      = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_sof,
  input  logic        in_href,
  input  logic [23:0] in_rgb,
  output logic        out_href,
  output logic [7:0]  out_raw,
  output logic        out_eol,
  output logic        out_eof,
  output logic [15:0] frame_cnt
);

  localparam logic [10:0] H_LAST   = RAW_HPIXEL - 11'd1;
  localparam logic [10:0] V_LAST   = RAW_VPIXEL - 11'd1;
  localparam logic [1:0]  BAYER_PH = 2'(BAYER);

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic        out_href_q, out_href_d;
  logic [7:0]  out_raw_q, out_raw_d;
  logic        out_eol_q, out_eol_d;
  logic        out_eof_q, out_eof_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic [10:0] h_cur, v_cur;
  logic [1:0]  ph;
  logic [7:0]  sel;
  logic        last_h, last_v;

  always_comb begin
    // SOF re-addresses the pixel on the same cycle as (0,0)
    h_cur  = in_sof ? 11'd0 : h_cnt_q;
    v_cur  = in_sof ? 11'd0 : v_cnt_q;
    ph     = {v_cur[0], h_cur[0]} ^ BAYER_PH;
    last_h = (h_cur == H_LAST);
    last_v = (v_cur == V_LAST);

    case (ph)
      2'b00:   sel = in_rgb[7:0];
      2'b11:   sel = in_rgb[23:16];
      default: sel = in_rgb[15:8];
    endcase

    h_cnt_d = h_cur;
    v_cnt_d = v_cur;
    if (in_href) begin
      if (last_h) begin
        h_cnt_d = 11'd0;
        v_cnt_d = last_v ? 11'd0 : v_cur + 11'd1;
      end else begin
        h_cnt_d = h_cur + 11'd1;
      end
    end

    out_href_d  = in_href;
    out_raw_d   = in_href ? sel : 8'd0;
    out_eol_d   = in_href & last_h;
    out_eof_d   = in_href & last_h & last_v;
    frame_cnt_d = frame_cnt_q;
    if (out_eof_d) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      out_href_q  <= 1'b0;
      out_raw_q   <= '0;
      out_eol_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      out_href_q  <= out_href_d;
      out_raw_q   <= out_raw_d;
      out_eol_q   <= out_eol_d;
      out_eof_q   <= out_eof_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign out_href  = out_href_q;
  assign out_raw   = out_raw_q;
  assign out_eol   = out_eol_q;
  assign out_eof   = out_eof_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_rgb2bayer.sv
// Bench for rgb2bayer: five instances (all four CFA orders on 4x2, plus 5x3)
// checked each cycle against a pixel-index reference model.
module tb_rgb2bayer;

  localparam int N = 5;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_sof;
  logic        in_href;
  logic [23:0] in_rgb;

  logic        out_href  [N];
  logic [7:0]  out_raw   [N];
  logic        out_eol   [N];
  logic        out_eof   [N];
  logic [15:0] frame_cnt [N];

  int checks = 0;
  int errors = 0;

  int pix    [N];
  int frames [N];
  logic        e_href [N];
  logic [7:0]  e_raw  [N];
  logic        e_eol  [N];
  logic        e_eof  [N];

  always #5 clk = ~clk;

  function automatic int h_of(input int i); return (i == 4) ? 5 : 4; endfunction
  function automatic int v_of(input int i); return (i == 4) ? 3 : 2; endfunction
  function automatic int b_of(input int i); return (i == 4) ? 2 : i; endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    rgb2bayer #(
      .RAW_HPIXEL((g == 4) ? 11'd5 : 11'd4),
      .RAW_VPIXEL((g == 4) ? 11'd3 : 11'd2),
      .BAYER     ((g == 4) ? 2 : g)
    ) u_dut (
      .clk      (clk),
      .rstn     (rstn),
      .in_sof   (in_sof),
      .in_href  (in_href),
      .in_rgb   (in_rgb),
      .out_href (out_href[g]),
      .out_raw  (out_raw[g]),
      .out_eol  (out_eol[g]),
      .out_eof  (out_eof[g]),
      .frame_cnt(frame_cnt[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: pixel position is the running pixel index within the frame.
  task automatic model(input int i);
    int h, v, c;
    if (!rstn) begin
      pix[i] = 0; frames[i] = 0;
      e_href[i] = 0; e_raw[i] = 0; e_eol[i] = 0; e_eof[i] = 0;
      return;
    end
    if (in_sof) pix[i] = 0;
    e_href[i] = in_href;
    e_raw[i] = 0; e_eol[i] = 0; e_eof[i] = 0;
    if (in_href) begin
      h = pix[i] % h_of(i);
      v = pix[i] / h_of(i);
      c = ((v % 2) * 2 + (h % 2)) ^ b_of(i);
      if (c == 0)      e_raw[i] = in_rgb[7:0];
      else if (c == 3) e_raw[i] = in_rgb[23:16];
      else             e_raw[i] = in_rgb[15:8];
      e_eol[i] = (h == h_of(i) - 1);
      e_eof[i] = e_eol[i] && (v == v_of(i) - 1);
      if (e_eof[i]) frames[i] = (frames[i] + 1) % 65536;
      pix[i] = (pix[i] + 1) % (h_of(i) * v_of(i));
    end
  endtask

  task automatic step(input logic r, input logic s, input logic hr, input logic [23:0] rgb);
    @(negedge clk);
    rstn = r; in_sof = s; in_href = hr; in_rgb = rgb;
    for (int i = 0; i < N; i++) model(i);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("href%0d", i), 32'(out_href[i]), 32'(e_href[i]));
      chk($sformatf("raw%0d", i), 32'(out_raw[i]), 32'(e_raw[i]));
      chk($sformatf("eol%0d", i), 32'(out_eol[i]), 32'(e_eol[i]));
      chk($sformatf("eof%0d", i), 32'(out_eof[i]), 32'(e_eof[i]));
      chk($sformatf("fcnt%0d", i), 32'(frame_cnt[i]), 32'(frames[i]));
    end
  endtask

  initial begin
    logic [7:0] seq_b2 [8];
    logic [7:0] seq_b0 [8];
    seq_b2 = '{8'h20, 8'h30, 8'h20, 8'h30, 8'h10, 8'h20, 8'h10, 8'h20};
    seq_b0 = '{8'h10, 8'h20, 8'h10, 8'h20, 8'h20, 8'h30, 8'h20, 8'h30};
    rstn = 1'b0; in_sof = 1'b0; in_href = 1'b0; in_rgb = '0;

    // reset held with href active: all outputs must stay 0
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 24'($urandom));
    chk("rst_raw", 32'(out_raw[2]), 32'd0);

    // constant pixel over two frames: phase map, eol/eof and frame count
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b0, 1'b1, 24'h302010);
      chk("map_b2", 32'(out_raw[2]), 32'(seq_b2[k % 8]));
      chk("map_b0", 32'(out_raw[0]), 32'(seq_b0[k % 8]));
      chk("eol_pos", 32'(out_eol[0]), 32'((k % 4) == 3));
    end
    chk("fcnt_two", 32'(frame_cnt[0]), 32'd2);

    // gaps: alternate valid pixels
    for (int k = 0; k < 16; k++) step(1'b1, (k == 0), (k % 2) == 0, 24'($urandom));

    // early SOF mid-frame at row 1, column 2
    for (int k = 0; k < 6; k++) step(1'b1, (k == 0), 1'b1, 24'h302010);
    step(1'b1, 1'b1, 1'b1, 24'h302010);
    chk("esof_raw", 32'(out_raw[2]), 32'h20);
    chk("esof_eof", 32'(out_eof[0]), 32'd0);

    // randomized traffic including SOF, gaps and resets
    for (int k = 0; k < 3000; k++)
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 3) != 0), 24'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
